// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline stage.
//   ext_mode_t   : extension mode selected by the decoder
//   skid_state_t : occupancy of the 2-entry skid buffer
package imm_ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_LUI    = 2'd2,
        EXT_BR_OFS = 2'd3
    } ext_mode_t;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_FULL  = 2'd2
    } skid_state_t;

endpackage : imm_ext_pkg

// File: rtl/imm_extend_pipe_skid_buffer.sv
// Generic 2-entry skid buffer (main/output register + skid register) with a
// valid/ready handshake on both sides. in_ready is registered and never
// depends combinationally on out_ready.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
module skid_buffer
    import imm_ext_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    skid_state_t  next_state;
    logic [W-1:0] skid_data;
    logic         acc;
    logic         drain;
    logic         load_main;
    logic         load_skid;
    logic         skid_to_main;

    // Next-state and register-enable decode
    always_comb begin
        next_state   = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        acc          = in_valid & in_ready;
        drain        = out_valid & out_ready;
        case (state)
            SK_EMPTY: begin
                if (acc) begin
                    load_main  = 1'b1;
                    next_state = SK_ONE;
                end
            end
            SK_ONE: begin
                if (acc && drain) begin
                    load_main  = 1'b1;
                end else if (acc) begin
                    load_skid  = 1'b1;
                    next_state = SK_FULL;
                end else if (drain) begin
                    next_state = SK_EMPTY;
                end
            end
            SK_FULL: begin
                if (drain) begin
                    skid_to_main = 1'b1;
                    next_state   = SK_ONE;
                end
            end
            default: begin
                next_state = SK_EMPTY;
            end
        endcase
    end

    // State register plus registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SK_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != SK_EMPTY);
            in_ready  <= (next_state != SK_FULL);
        end
    end

    // Payload storage; only written on a qualified transfer so idle X never enters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                out_data <= in_data;
            end else if (skid_to_main) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule : skid_buffer

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit (decode -> execute). Extends an IN_W-bit
// immediate to OUT_W bits (sign / zero / LUI / branch offset) and passes the
// result with its tag through a 2-entry skid buffer. Latency 1, throughput 1.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : upstream handshake
//   in_imm, in_mode, in_tag    : immediate, ext_mode_t, sideband tag
//   out_valid/out_ready        : downstream handshake
//   out_data, out_tag, out_neg : result, its tag, result MSB
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg
);

    localparam int unsigned PAY_W = OUT_W + TAG_W;
    localparam int unsigned EXT_W = OUT_W - IN_W;

    if ((IN_W < 2) || (OUT_W < IN_W + 2)) begin : g_param_check
        $error("imm_extend_pipe: need IN_W >= 2 and OUT_W >= IN_W+2");
    end

    // Extension datapath
    function automatic logic [OUT_W-1:0] imm_extend(input logic [IN_W-1:0] imm,
                                                    input ext_mode_t      mode);
        logic [OUT_W-1:0] sx;
        logic [OUT_W-1:0] res;
        sx = {{EXT_W{imm[IN_W-1]}}, imm};
        case (mode)
            EXT_SIGN:   res = sx;
            EXT_ZERO:   res = {{EXT_W{1'b0}}, imm};
            EXT_LUI:    res = {imm, {EXT_W{1'b0}}};
            EXT_BR_OFS: res = {sx[OUT_W-3:0], 2'b00};
            default:    res = sx;
        endcase
        return res;
    endfunction

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign pay_in = {in_tag, imm_extend(in_imm, ext_mode_t'(in_mode))};

    skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    // Result fields come straight from the buffer's output register
    assign out_data = pay_out[OUT_W-1:0];
    assign out_tag  = pay_out[PAY_W-1:OUT_W];
    assign out_neg  = pay_out[OUT_W-1];

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_imm_extend_pipe;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_neg;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Expected results in flight, {tag, data}, oldest first
    logic [TAG_W+OUT_W-1:0] q[$];

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_neg   (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension using plain arithmetic
    function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        logic [31:0] r;
        s = 32'($signed(imm));
        case (mode)
            2'd0:    r = s;
            2'd1:    r = 32'(imm);
            2'd2:    r = 32'(imm) << 16;
            default: r = s << 2;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference queue
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("mon_out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("mon_in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (out_valid && q.size() != 0) begin
                check("mon_out_data", 64'(out_data), 64'(q[0][OUT_W-1:0]));
                check("mon_out_tag", 64'(out_tag), 64'(q[0][TAG_W+OUT_W-1:OUT_W]));
                check("mon_out_neg", 64'(out_neg), 64'(q[0][OUT_W-1]));
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back({in_tag, model_ext(in_imm, in_mode)});
        end
    end

    task automatic set_in(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    // One transfer with out_ready=1; result checked one cycle later against literals
    task automatic send_check(input string name, input logic [15:0] imm, input logic [1:0] mode,
                              input logic [4:0] tag, input logic [31:0] exp_d, input logic exp_n);
        set_in(imm, mode, tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"}, 64'(out_data), 64'(exp_d));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        check({name, "_neg"}, 64'(out_neg), 64'(exp_n));
    endtask

    logic [15:0] b2b_imm[4] = '{16'h0001, 16'h8000, 16'h0FFF, 16'hFFFF};
    logic [31:0] b2b_exp[4] = '{32'h00000001, 32'hFFFF8000, 32'h00000FFF, 32'hFFFFFFFF};

    initial begin
        bit acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_neg", 64'(out_neg), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #11 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Pin the reference model to hand-computed values
        check("model_sign", 64'(model_ext(16'h8000, 2'd0)), 64'h0000_0000_FFFF_8000);
        check("model_zero", 64'(model_ext(16'h8000, 2'd1)), 64'h0000_0000_0000_8000);
        check("model_lui", 64'(model_ext(16'h1234, 2'd2)), 64'h0000_0000_1234_0000);
        check("model_br", 64'(model_ext(16'h0FFF, 2'd3)), 64'h0000_0000_0000_3FFC);

        // Modes and branch offsets
        send_check("sign", 16'h8000, 2'd0, 5'd1, 32'hFFFF8000, 1'b1);
        send_check("zero", 16'h8000, 2'd1, 5'd2, 32'h00008000, 1'b0);
        send_check("lui", 16'h1234, 2'd2, 5'd3, 32'h12340000, 1'b0);
        send_check("br_m1", 16'hFFFF, 2'd3, 5'd4, 32'hFFFFFFFC, 1'b1);
        send_check("br_fff", 16'h0FFF, 2'd3, 5'd5, 32'h00003FFC, 1'b0);
        send_check("br_1", 16'h0001, 2'd3, 5'd7, 32'h00000004, 1'b0);
        @(posedge clk); #1;

        // Back-to-back: accept and drain every cycle, state stays ONE
        set_in(b2b_imm[0], 2'd0, 5'd10);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_data", 64'(out_data), 64'(b2b_exp[i]));
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            if (i < 3) set_in(b2b_imm[i+1], 2'd0, 5'(11 + i));
            else in_valid = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b_drained", 64'(out_valid), 64'd0);

        // Backpressure: third input refused while both entries are held
        out_ready = 1'b0;
        set_in(16'h0011, 2'd1, 5'd20);
        @(posedge clk); #1;
        set_in(16'h0022, 2'd1, 5'd21);
        @(posedge clk); #1;
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold_data", 64'(out_data), 64'h11);
        set_in(16'h0033, 2'd1, 5'd22);
        @(posedge clk); #1;
        check("bp_refuse_in_ready", 64'(in_ready), 64'd0);
        check("bp_stable_data", 64'(out_data), 64'h11);
        check("bp_stable_tag", 64'(out_tag), 64'd20);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_skid_to_main", 64'(out_data), 64'h22);
        check("bp_in_ready_up", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_third", 64'(out_data), 64'h33);
        check("bp_third_tag", 64'(out_tag), 64'd22);
        @(posedge clk); #1;
        check("bp_empty", 64'(out_valid), 64'd0);

        // Reset while FULL
        out_ready = 1'b0;
        set_in(16'hABCD, 2'd0, 5'd30);
        @(posedge clk); #1;
        set_in(16'h1357, 2'd0, 5'd31);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmid_full", 64'(in_ready), 64'd0);
        #3 rst_n = 1'b0;
        q.delete();
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        check("rstmid_no_stale", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic; upstream holds a refused offer
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_imm   = 16'($urandom);
                in_mode  = 2'($urandom_range(0, 3));
                in_tag   = 5'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (!acc && in_valid) begin
            // let the pending offer complete before draining
            for (int w = 0; w < 10 && !(in_valid && in_ready); w++) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
        #1;
        check("final_drain", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imm_extend_pipe
